udp_send_buffer: RTL and testbench
==================================

UDP_SEND_BUFFER -- requirements
Module: udp_send_buffer

Interface
REQ-001 The block SHALL have parameter P_MAX_LEN, default 16'd1472, the maximum UDP payload bytes per frame.
REQ-002 The block SHALL have parameter P_ADDR_W, default 11, the buffer address width; 2^P_ADDR_W SHALL be at least P_MAX_LEN.
REQ-003 i_clk  input  1  sole clock; every register SHALL be clocked on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_user_data  input  8  payload byte from the application.
REQ-006 i_user_last  input  1  marks the final byte of a frame.
REQ-007 i_user_valid  input  1  marks a valid input byte; a byte is accepted when i_user_valid and o_user_ready are both high.
REQ-008 o_user_ready  output  1  the block can accept a byte.
REQ-009 o_send_udp_data  output  8  payload byte to the UDP transmit stage.
REQ-010 o_send_udp_len  output  16  payload byte count of the current frame.
REQ-011 o_send_udp_last  output  1  final byte of the output frame.
REQ-012 o_send_udp_valid  output  1  output byte valid; the output has no backpressure.
REQ-013 o_overflow  output  1  one-cycle pulse when a frame is truncated.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, DROP and SEND.
REQ-015 o_user_ready SHALL be high in IDLE, FILL and DROP, and low in SEND.
REQ-016 IDLE/FILL: each accepted byte SHALL be written to the buffer at the address wr_cnt, and wr_cnt SHALL then increment.
  - The first accepted byte SHALL move the FSM from IDLE to FILL.
REQ-017 An accepted byte with i_user_last=1 SHALL latch the frame length as wr_cnt+1 and move the FSM to SEND on the next cycle.
  - This applies to a single-byte frame accepted in IDLE.
REQ-018 An accepted byte with wr_cnt = P_MAX_LEN-1 and i_user_last=0 SHALL:
  - be stored as the final byte;
  - latch the length as P_MAX_LEN;
  - pulse o_overflow for one cycle;
  - move the FSM to DROP.
REQ-019 DROP SHALL discard accepted bytes up to and including the byte with i_user_last=1, then move the FSM to SEND.
REQ-020 SEND SHALL issue reads at the addresses 0..len-1 on consecutive cycles, starting the cycle after the FSM enters SEND; the buffer SHALL have a one-cycle read latency.
REQ-021 o_send_udp_valid SHALL be high for exactly len consecutive cycles, with the first byte appearing 2 cycles after the cycle in which the last byte was accepted.
REQ-022 o_send_udp_len SHALL hold the latched length, stable for every cycle in which o_send_udp_valid is high; o_send_udp_len SHALL be 0 in every other cycle.
REQ-023 o_send_udp_last SHALL be high only together with the len-th output byte.
REQ-024 After the cycle carrying the last output byte, the FSM SHALL return to IDLE; o_user_ready SHALL rise in the following cycle.
REQ-025 When o_send_udp_valid is low, o_send_udp_data SHALL be 0.
REQ-026 wr_cnt and rd_cnt SHALL be 16 bits wide, SHALL never wrap within a frame, and SHALL clear to 0 on entry to IDLE.
REQ-027 Input with i_user_valid high while o_user_ready is low SHALL be ignored; the upstream block holds data until it is accepted.

Reset
REQ-028 When i_rst is high at a clock edge, the following SHALL apply at that edge:
  - FSM = IDLE;
  - wr_cnt = 0, rd_cnt = 0, latched len = 0;
  - all outputs = 0, except o_user_ready, which SHALL be 1 from the first cycle after reset.
REQ-029 Reset during FILL, DROP or SEND SHALL abandon the frame with no further output bytes; buffer contents need not be cleared.

Structure
REQ-030 P_MAX_LEN, the FSM state encodings and the UDP/IP length constants (header sizes 8 and 20) SHALL live in a shared package used by the UDP and IP stages.
REQ-031 The buffer SHALL be one sub-module, udp_buf_ram: a simple dual-port RAM, 8 bits × 2^P_ADDR_W, with a registered read and a one-cycle read latency.

Verification
REQ-032 The bench SHALL drive 5 bytes 0x11..0x15 with last on 0x15 and require o_send_udp_valid for 5 cycles, len=5, data 0x11..0x15, and last on 0x15, starting 2 cycles after 0x15 is accepted.
REQ-033 The bench SHALL drive a single byte 0xA5 with last and require one valid cycle with len=1, last=1 and data=0xA5.
REQ-034 The bench SHALL drive 1500 bytes with last on byte 1500 and require:
  - an o_overflow pulse on the accept of byte 1472;
  - output len=1472 of bytes 1..1472;
  - bytes 1473..1500 discarded.
REQ-035 The bench SHALL hold i_user_valid high across two back-to-back frames of 3 and 4 bytes and require:
  - o_user_ready low throughout the first frame's SEND;
  - the second frame output intact with len=4 and no byte lost.
REQ-036 The bench SHALL assert i_rst on the 3rd output byte of a 10-byte frame and require all outputs 0 from the next cycle, o_user_ready=1 after reset, and a following 2-byte frame output correctly.

Source files
------------

// File: rtl/udp_send_buffer_pkg.sv
// Shared constants and state type for the UDP/IP transmit path.
package udp_send_buffer_pkg;

    localparam logic [15:0] UdpMaxLen = 16'd1472;
    localparam logic [15:0] UdpHdrLen = 16'd8;
    localparam logic [15:0] IpHdrLen  = 16'd20;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrop,
        StSend
    } udp_state_e;

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port byte RAM with a registered read port (one-cycle read latency).
module udp_buf_ram #(
    parameter int unsigned AddrW = 11
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] mem_q [0:(1<<AddrW)-1];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/udp_send_buffer.sv
// Collects one application frame into a buffer, truncating at P_MAX_LEN, then
// replays it to the UDP transmit stage with its length attached.
module udp_send_buffer
    import udp_send_buffer_pkg::*;
#(
    parameter logic [15:0] P_MAX_LEN = UdpMaxLen,
    parameter int unsigned P_ADDR_W  = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_user_data,
    input  logic        i_user_last,
    input  logic        i_user_valid,
    output logic        o_user_ready,
    output logic [7:0]  o_send_udp_data,
    output logic [15:0] o_send_udp_len,
    output logic        o_send_udp_last,
    output logic        o_send_udp_valid,
    output logic        o_overflow
);

    udp_state_e  state_q, state_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] len_q, len_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  rd_data;

    assign o_user_ready = (state_q != StSend);
    assign accept       = i_user_valid && o_user_ready;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        len_d    = len_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        ovf_d    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            StIdle, StFill: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    state_d  = StFill;
                    if (i_user_last) begin
                        len_d   = wr_cnt_q + 16'd1;
                        state_d = StSend;
                    end else if (wr_cnt_q == P_MAX_LEN - 16'd1) begin
                        // Buffer full: keep this byte as the last one, drop the rest.
                        len_d   = P_MAX_LEN;
                        ovf_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
            end
            StDrop: begin
                if (accept && i_user_last) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (rd_cnt_q < len_q) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 16'd1;
                    valid_d  = 1'b1;
                    last_d   = (rd_cnt_q == len_q - 16'd1);
                end
                if (last_q) begin
                    state_d  = StIdle;
                    wr_cnt_d = 16'd0;
                    rd_cnt_d = 16'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
            len_q    <= 16'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    udp_buf_ram #(
        .AddrW(P_ADDR_W)
    ) u_buf (
        .clk_i    (i_clk),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_cnt_q[P_ADDR_W-1:0]),
        .wr_data_i(i_user_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_cnt_q[P_ADDR_W-1:0]),
        .rd_data_o(rd_data)
    );

    // RAM read data is only meaningful alongside valid_q; zero it otherwise.
    assign o_send_udp_valid = valid_q;
    assign o_send_udp_last  = last_q;
    assign o_send_udp_data  = valid_q ? rd_data : 8'd0;
    assign o_send_udp_len   = valid_q ? len_q : 16'd0;
    assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_udp_send_buffer.sv
// Self-checking bench for udp_send_buffer: directed and random frames checked
// against a frame-level scoreboard of expected output bytes and cycles.
module tb_udp_send_buffer;

    localparam int MaxLen = 1472;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  user_data = 8'd0;
    logic        user_last = 1'b0;
    logic        user_valid = 1'b0;
    logic        user_ready;
    logic [7:0]  send_data;
    logic [15:0] send_len;
    logic        send_last;
    logic        send_valid;
    logic        overflow;

    udp_send_buffer #(
        .P_MAX_LEN(16'd1472),
        .P_ADDR_W (11)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_user_data     (user_data),
        .i_user_last     (user_last),
        .i_user_valid    (user_valid),
        .o_user_ready    (user_ready),
        .o_send_udp_data (send_data),
        .o_send_udp_len  (send_len),
        .o_send_udp_last (send_last),
        .o_send_udp_valid(send_valid),
        .o_overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: one entry per expected output byte.
    logic [7:0] exp_data[$];
    int         exp_len[$];
    bit         exp_last[$];
    int         exp_cyc[$];
    logic [7:0] fbuf[0:1499];

    int ovf_cnt = 0;
    int ovf_cyc = -1;
    int exp_ovf_n = 0;
    int exp_ovf_cyc = -1;
    int seen_in_frame = 0;
    bit mon_en = 1'b0;
    bit ready_due = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ready_due) begin
                check("ready_after_frame", 32'(user_ready), 32'd1);
                ready_due = 1'b0;
            end
            if (overflow) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
            if (!send_valid) begin
                check("data_idle", 32'(send_data), 32'd0);
                check("len_idle", 32'(send_len), 32'd0);
                check("last_idle", 32'(send_last), 32'd0);
            end else if (exp_data.size() == 0) begin
                check("unexpected_valid", 32'(send_valid), 32'd0);
            end else begin
                check("out_cycle", cyc, exp_cyc[0]);
                check("out_data", 32'(send_data), 32'(exp_data[0]));
                check("out_len", 32'(send_len), exp_len[0]);
                check("out_last", 32'(send_last), 32'(exp_last[0]));
                check("ready_in_send", 32'(user_ready), 32'd0);
                seen_in_frame++;
                if (exp_last[0]) begin
                    ready_due = 1'b1;
                    seen_in_frame = 0;
                end
                void'(exp_data.pop_front());
                void'(exp_len.pop_front());
                void'(exp_last.pop_front());
                void'(exp_cyc.pop_front());
            end
        end
    end

    // Present one byte and hold it until the DUT is ready; acc is the cycle
    // stamp of the clock edge that accepts it.
    task automatic drive_byte(input logic [7:0] d, input logic l, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        user_data  = d;
        user_last  = l;
        user_valid = 1'b1;
        while (!user_ready && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (!user_ready) begin
            errors++;
            $display("FAIL ready_timeout: ready stuck low for %0d cycles", guard);
            $fatal(1, "input never accepted");
        end
        acc = cyc;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        user_valid = 1'b0;
        user_last  = 1'b0;
    endtask

    // Frame-level reference: first min(n, MaxLen) bytes come out, starting two
    // cycles after the final input byte is accepted, one byte per cycle.
    task automatic send_frame(input int n, input bit gaps);
        int n_eff;
        int acc;
        n_eff = (n > MaxLen) ? MaxLen : n;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    user_valid = 1'b0;
                end
            end
            drive_byte(fbuf[i], (i == n - 1), acc);
            if (i == MaxLen - 1 && n > MaxLen) begin
                exp_ovf_n++;
                exp_ovf_cyc = acc + 1;
            end
        end
        for (int i = 0; i < n_eff; i++) begin
            exp_data.push_back(fbuf[i]);
            exp_len.push_back(n_eff);
            exp_last.push_back(i == n_eff - 1);
            exp_cyc.push_back(acc + 2 + i);
        end
    endtask

    task automatic drain_and_check();
        int guard;
        guard = 0;
        while (exp_data.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_complete", exp_data.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("ovf_count", ovf_cnt, exp_ovf_n);
        check("ovf_cycle", ovf_cyc, exp_ovf_cyc);
    endtask

    initial begin
        int n;
        int guard;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(send_valid), 32'd0);
        check("rst_data", 32'(send_data), 32'd0);
        check("rst_len", 32'(send_len), 32'd0);
        check("rst_last", 32'(send_last), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready", 32'(user_ready), 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Five-byte frame 0x11..0x15.
        for (int i = 0; i < 5; i++) fbuf[i] = 8'h11 + 8'(i);
        send_frame(5, 1'b0);
        idle_inputs();
        drain_and_check();

        // Single-byte frame.
        fbuf[0] = 8'hA5;
        send_frame(1, 1'b0);
        idle_inputs();
        drain_and_check();

        // Back-to-back 3- and 4-byte frames with valid held high.
        for (int i = 0; i < 3; i++) fbuf[i] = 8'($urandom);
        send_frame(3, 1'b0);
        @(negedge clk);
        check("ready_low_send_entry", 32'(user_ready), 32'd0);
        for (int i = 0; i < 4; i++) fbuf[i] = 8'($urandom);
        send_frame(4, 1'b0);
        idle_inputs();
        drain_and_check();

        // Reset on the third output byte of a 10-byte frame.
        for (int i = 0; i < 10; i++) fbuf[i] = 8'($urandom);
        seen_in_frame = 0;
        send_frame(10, 1'b0);
        idle_inputs();
        guard = 0;
        while (seen_in_frame != 3 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reached_third_byte", seen_in_frame, 32'd3);
        rst = 1'b1;
        exp_data.delete();
        exp_len.delete();
        exp_last.delete();
        exp_cyc.delete();
        @(negedge clk);
        check("midrst_valid", 32'(send_valid), 32'd0);
        check("midrst_data", 32'(send_data), 32'd0);
        check("midrst_len", 32'(send_len), 32'd0);
        check("midrst_last", 32'(send_last), 32'd0);
        check("midrst_ready", 32'(user_ready), 32'd1);
        rst = 1'b0;
        seen_in_frame = 0;
        repeat (3) @(negedge clk);
        fbuf[0] = 8'($urandom);
        fbuf[1] = 8'($urandom);
        send_frame(2, 1'b0);
        idle_inputs();
        drain_and_check();

        // Random short frames with random input gaps.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
            send_frame(n, 1'b1);
            idle_inputs();
            drain_and_check();
        end

        // Length boundaries: exactly full, one over, far over.
        for (int i = 0; i < 1500; i++) fbuf[i] = 8'($urandom);
        send_frame(MaxLen, 1'b0);
        idle_inputs();
        drain_and_check();
        send_frame(MaxLen + 1, 1'b0);
        idle_inputs();
        drain_and_check();
        send_frame(1500, 1'b0);
        idle_inputs();
        drain_and_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
